seg_pattern_reader: RTL and testbench

Monitors a multiplexed, active-low 7-segment display bus (segment lines plus active-low digit selects) and recovers the hex value shown on each digit. It is the inverse of the team's hex-to-segment decoder. It sits on the stopwatch board's display lines as a self-check and readback block. Inputs are synchronised and must be stable for a programmable number of cycles before a digit is committed. This filters ghosting during scan transitions.

---
 rtl/seg_pattern_reader.sv | 147 ++++++++++++++
 tb/tb_seg_pattern_reader.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seg_pattern_reader.sv
// seg_pattern_reader: watches a multiplexed active-low 7-segment bus and
// recovers the hex nibble shown on each digit. A value is committed only
// after it has been stable for STABLE_CYC synchronised samples.
module seg_pattern_reader #(
  parameter int NUM_DIG    = 4,
  parameter int IDX_W      = 2,
  parameter int STABLE_CYC = 4
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic [6:0]           iSEG,
  input  logic [NUM_DIG-1:0]   iDIG_N,
  output logic [4*NUM_DIG-1:0] oHEX,
  output logic [NUM_DIG-1:0]   oVALID,
  output logic [NUM_DIG-1:0]   oERR,
  output logic                 oUPD,
  output logic [IDX_W-1:0]     oUPD_IDX
);

  localparam int SW = NUM_DIG + 7;

  logic [SW-1:0]        sync1_q, sync1_d;
  logic [SW-1:0]        sync2_q, sync2_d;
  logic [SW-1:0]        prev_q, prev_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [4*NUM_DIG-1:0] hex_q, hex_d;
  logic [NUM_DIG-1:0]   valid_q, valid_d;
  logic [NUM_DIG-1:0]   err_q, err_d;
  logic                 upd_q, upd_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  logic [NUM_DIG-1:0]   sel_on;
  logic [6:0]           seg;
  logic                 sel_ok;
  logic                 same;
  logic                 commit;
  logic [IDX_W-1:0]     sel_idx;
  logic                 glyph_hit;
  logic [3:0]           glyph_val;

  // Inverse glyph lookup on the active-low gfedcba pattern
  always_comb begin
    glyph_hit = 1'b1;
    glyph_val = 4'h0;
    case (seg)
      7'b1000000: glyph_val = 4'h0;
      7'b1111001: glyph_val = 4'h1;
      7'b0100100: glyph_val = 4'h2;
      7'b0110000: glyph_val = 4'h3;
      7'b0011001: glyph_val = 4'h4;
      7'b0010010: glyph_val = 4'h5;
      7'b0000010: glyph_val = 4'h6;
      7'b1111000: glyph_val = 4'h7;
      7'b0000000: glyph_val = 4'h8;
      7'b0011000: glyph_val = 4'h9;
      7'b0001000: glyph_val = 4'hA;
      7'b0000011: glyph_val = 4'hB;
      7'b1000110: glyph_val = 4'hC;
      7'b0100001: glyph_val = 4'hD;
      7'b0000110: glyph_val = 4'hE;
      7'b0001110: glyph_val = 4'hF;
      default:    glyph_hit = 1'b0;
    endcase
  end

  // Select decode, stability counter and commit decision
  always_comb begin
    sync1_d = {iDIG_N, iSEG};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    seg     = sync2_q[6:0];
    sel_on  = ~sync2_q[SW-1:7];
    // exactly one select low: nonzero and a power of two
    sel_ok  = (sel_on != '0) && ((sel_on & (sel_on - NUM_DIG'(1))) == '0);
    sel_idx = '0;
    for (int i = 0; i < NUM_DIG; i++)
      if (sel_on[i]) sel_idx = IDX_W'(i);
    same = (sync2_q == prev_q);

    if (!sel_ok)                                cnt_d = 8'd0;
    else if (!same)                             cnt_d = 8'd1;
    else if (cnt_q < 8'(STABLE_CYC))            cnt_d = cnt_q + 8'd1;
    else                                        cnt_d = cnt_q;

    // the single edge where the count reaches STABLE_CYC
    commit = sel_ok && same && (cnt_q == 8'(STABLE_CYC - 1));
  end

  // Per-digit output update on commit; other digits hold
  always_comb begin
    hex_d   = hex_q;
    valid_d = valid_q;
    err_d   = err_q;
    upd_d   = commit;
    idx_d   = commit ? sel_idx : idx_q;
    if (commit) begin
      for (int i = 0; i < NUM_DIG; i++) begin
        if (sel_on[i]) begin
          if (glyph_hit) begin
            hex_d[4*i +: 4] = glyph_val;
            valid_d[i]      = 1'b1;
            err_d[i]        = 1'b0;
          end else if (seg == 7'b1111111) begin
            hex_d[4*i +: 4] = 4'h0;
            valid_d[i]      = 1'b0;
            err_d[i]        = 1'b0;
          end else begin
            valid_d[i]      = 1'b0;
            err_d[i]        = 1'b1;
          end
        end
      end
    end
  end

  // State registers; reset looks like a blanked bus with no select
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
      cnt_q   <= 8'd0;
      hex_q   <= '0;
      valid_q <= '0;
      err_q   <= '0;
      upd_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      upd_q   <= upd_d;
      idx_q   <= idx_d;
    end
  end

  assign oHEX     = hex_q;
  assign oVALID   = valid_q;
  assign oERR     = err_q;
  assign oUPD     = upd_q;
  assign oUPD_IDX = idx_q;

endmodule

// File: tb/tb_seg_pattern_reader.sv
// Directed bench for seg_pattern_reader with hand-computed expectations.
module tb_seg_pattern_reader;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg;
  logic [ND-1:0] dig_n;
  logic [4*ND-1:0] hex;
  logic [ND-1:0] valid, err;
  logic          upd;
  logic [1:0]    upd_idx;

  int total = 0;
  int bad   = 0;

  // pulse monitor
  int       upd_cnt  = 0;
  logic     upd_prev = 1'b0;
  int       dbl_cnt  = 0;
  logic [1:0] idx_log[$];

  seg_pattern_reader #(.NUM_DIG(ND), .IDX_W(2), .STABLE_CYC(4)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iSEG(seg), .iDIG_N(dig_n),
    .oHEX(hex), .oVALID(valid), .oERR(err), .oUPD(upd), .oUPD_IDX(upd_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && upd === 1'b1) begin
      upd_cnt++;
      idx_log.push_back(upd_idx);
      if (upd_prev) dbl_cnt++;
    end
    upd_prev = (rst_n === 1'b1) && (upd === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [ND-1:0] d, input logic [6:0] s);
    dig_n = d;
    seg   = s;
  endtask

  int base;
  logic [15:0] sv_hex;
  logic [3:0]  sv_val, sv_err;

  initial begin
    rst_n = 1'b0;
    put(4'b1111, 7'b1111111);
    step(3);
    chk("rst_hex", hex, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_upd", {upd, upd_idx}, 0);
    rst_n = 1'b1;
    step(2);

    // 1: digit 0 shows 2, commit exactly on edge k+5
    put(4'b1110, 7'b0100100);
    step(5);
    chk("t1_early", upd, 0);
    step(1);
    chk("t1_upd", upd, 1);
    chk("t1_idx", upd_idx, 0);
    chk("t1_nib", hex[3:0], 4'h2);
    chk("t1_valid", valid, 4'b0001);
    chk("t1_err", err, 4'b0000);
    step(1);
    chk("t1_fall", upd, 0);
    step(10);
    chk("t1_once", upd_cnt, 1);

    // 2: scan 1,9,A,F with 8 cycles per digit
    base = upd_cnt;
    idx_log.delete();
    put(4'b1110, 7'b1111001); step(8);
    put(4'b1101, 7'b0011000); step(8);
    put(4'b1011, 7'b0001000); step(8);
    put(4'b0111, 7'b0001110); step(8);
    put(4'b1111, 7'b1111111); step(6);
    chk("t2_hex", hex, 16'hFA91);
    chk("t2_valid", valid, 4'b1111);
    chk("t2_pulses", upd_cnt - base, 4);
    if (idx_log.size() == 4)
      chk("t2_idx", {idx_log[0], idx_log[1], idx_log[2], idx_log[3]}, 8'b00_01_10_11);
    else
      chk("t2_idxlog", idx_log.size(), 4);

    // 3: digit 1 at 8, two-cycle glitch to 1, back to 8
    put(4'b1101, 7'b0000000); step(10);
    chk("t3_first", hex[7:4], 4'h8);
    base = upd_cnt;
    idx_log.delete();
    put(4'b1101, 7'b1111001); step(2);
    chk("t3_glitch", hex[7:4], 4'h8);
    put(4'b1101, 7'b0000000); step(10);
    chk("t3_pulses", upd_cnt - base, 1);
    chk("t3_nib", hex[7:4], 4'h8);
    chk("t3_idx", upd_idx, 1);
    chk("t3_hex", hex, 16'hFA81);

    // 4: illegal selects never commit
    base = upd_cnt;
    sv_hex = hex; sv_val = valid; sv_err = err;
    put(4'b1010, 7'b0100100); step(20);
    put(4'b1111, 7'b0100100); step(20);
    chk("t4_pulses", upd_cnt - base, 0);
    chk("t4_hex", hex, sv_hex);
    chk("t4_valid", valid, sv_val);
    chk("t4_err", err, sv_err);

    // 5: illegal glyph then blank on digit 3
    put(4'b0111, 7'b0101010); step(8);
    chk("t5_err", err, 4'b1000);
    chk("t5_valid", valid, 4'b0111);
    chk("t5_hex", hex, 16'hFA81);
    put(4'b0111, 7'b1111111); step(8);
    chk("t5b_err", err, 4'b0000);
    chk("t5b_valid", valid, 4'b0111);
    chk("t5b_hex", hex, 16'h0A81);

    // 6: reset in the middle of a window on digit 2 showing E
    put(4'b1011, 7'b0000110); step(3);
    rst_n = 1'b0;
    #1;
    chk("t6_hex0", hex, 0);
    chk("t6_vld0", {valid, err}, 0);
    chk("t6_upd0", {upd, upd_idx}, 0);
    step(2);
    rst_n = 1'b1;
    base = upd_cnt;
    step(5);
    chk("t6_early", upd_cnt - base, 0);
    step(1);
    chk("t6_upd", upd, 1);
    chk("t6_idx", upd_idx, 2);
    chk("t6_hex", hex, 16'h0E00);
    chk("t6_valid", valid, 4'b0100);
    step(4);

    chk("no_double", dbl_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
